// File: rtl/fifo_ctrl_gen2_pkg.sv
// fifo_pkg: constants and helpers shared by the FIFO controller slice.
//   clog2          - constant function for deriving address and count widths
//   FIFO_DEPTH_DEF - default storage depth
//   FIFO_AE_DEF    - default almost-empty threshold
package fifo_pkg;

  // Bounded loop so the function is also usable in synthesis elaboration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned FIFO_DEPTH_DEF = 13;
  localparam int unsigned FIFO_AE_DEF    = 1;

endpackage

// File: rtl/fifo_ctrl_gen2_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer that wraps explicitly at DEPTH-1.
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   clr   - synchronous flush, same effect as reset
//   inc   - advance the pointer by one entry
//   ptr   - current pointer value
module fifo_wrap_ptr #(
  parameter int unsigned DEPTH      = 13,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  // Compare against the last index instead of relying on power-of-2 rollover.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) ptr_q <= '0;
    else              ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl_gen2.sv
// fifo_ctrl_gen2: pointer/flag controller for a FIFO built on an external
// dual-port RAM. Handles any DEPTH >= 2, including non-power-of-2.
//   clk, reset, clr     - clock, synchronous reset, synchronous flush
//   w_en, r_en          - write / read requests
//   w_we, r_re          - accepted write / read strobes to the RAM (comb)
//   w_addr, r_addr      - registered RAM write / read addresses
//   count               - occupancy 0..DEPTH
//   full, empty         - registered occupancy flags
//   almost_full/empty   - registered threshold flags
//   overflow, underflow - sticky error flags, cleared by reset/clr
module fifo_ctrl_gen2
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = FIFO_DEPTH_DEF,
  parameter int unsigned ADDR_WIDTH = clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = clog2(DEPTH + 1),
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = FIFO_AE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  w_en,
  input  logic                  r_en,
  output logic                  w_we,
  output logic                  r_re,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_THRESH);

  logic                 flush;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_q, empty_q, af_q, ae_q, ovf_q, udf_q;

  // A flush drops same-cycle requests, so strobes are masked and no error is raised.
  assign flush = reset | clr;
  assign r_re  = r_en & ~empty_q & ~flush;
  // At full, a same-cycle read frees the slot the write lands in.
  assign w_we  = w_en & (~full_q | r_re) & ~flush;

  always_comb begin
    count_d = count_q + CNT_WIDTH'(w_we) - CNT_WIDTH'(r_re);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= AF_C);
      ae_q    <= (count_d <= AE_C);
      if (w_en && !w_we) ovf_q <= 1'b1;
      if (r_en && !r_re) udf_q <= 1'b1;
    end
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_we),
    .ptr   (w_addr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (r_re),
    .ptr   (r_addr)
  );

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_gen2.sv
// Directed bench for fifo_ctrl_gen2 at DEPTH=13, AF_THRESH=11, AE_THRESH=1.
module tb_fifo_ctrl_gen2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic       w_we, r_re;
  logic [3:0] w_addr, r_addr;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int errors = 0;
  int checks = 0;

  fifo_ctrl_gen2 #(.DEPTH(13)) dut (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr),
    .w_en         (w_en),
    .r_en         (r_en),
    .w_we         (w_we),
    .r_re         (r_re),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clr = 1'b0; w_en = 1'b0; r_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
    checks++; if (w_addr !== 4'd0 || r_addr !== 4'd0) begin errors++; $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", w_addr, r_addr); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_a;
    logic [3:0] k;
    for (int i = 0; i < 13; i++) begin
      exp_a = 4'(i);
      k = 4'(i + 1);
      w_en = 1'b1;
      #1;
      checks++; if (w_we !== 1'b1) begin errors++; $display("FAIL fill_we[%0d] got=%b exp=1", i, w_we); end
      checks++; if (w_addr !== exp_a) begin errors++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, w_addr, exp_a); end
      tick();
      w_en = 1'b0;
      checks++; if (count !== k) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, k); end
      checks++; if (almost_full !== (k >= 4'd11)) begin errors++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (k >= 4'd11)); end
      checks++; if (almost_empty !== (k <= 4'd1)) begin errors++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, (k <= 4'd1)); end
      checks++; if (full !== (k == 4'd13)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (k == 4'd13)); end
    end
    checks++; if (w_addr !== 4'd0) begin errors++; $display("FAIL fill_wrap got=%0d exp=0", w_addr); end
    // 14th write is refused
    w_en = 1'b1;
    #1;
    checks++; if (w_we !== 1'b0) begin errors++; $display("FAIL ovf_we got=%b exp=0", w_we); end
    tick();
    w_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (count !== 4'd13) begin errors++; $display("FAIL ovf_count got=%0d exp=13", count); end
    checks++; if (w_addr !== 4'd0) begin errors++; $display("FAIL ovf_waddr got=%0d exp=0", w_addr); end
  endtask

  task automatic test_full_rw();
    w_en = 1'b1; r_en = 1'b1;
    #1;
    checks++; if ({w_we, r_re} !== 2'b11) begin errors++; $display("FAIL fullrw_strobes got=%b%b exp=11", w_we, r_re); end
    tick();
    w_en = 1'b0; r_en = 1'b0;
    checks++; if (count !== 4'd13) begin errors++; $display("FAIL fullrw_count got=%0d exp=13", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullrw_full got=%b exp=1", full); end
    checks++; if (w_addr !== 4'd1 || r_addr !== 4'd1) begin errors++; $display("FAIL fullrw_ptrs got=%0d/%0d exp=1/1", w_addr, r_addr); end
  endtask

  task automatic test_empty_rw();
    do_reset();
    w_en = 1'b1; r_en = 1'b1;
    #1;
    checks++; if ({w_we, r_re} !== 2'b10) begin errors++; $display("FAIL emptyrw_strobes got=%b%b exp=10", w_we, r_re); end
    tick();
    w_en = 1'b0; r_en = 1'b0;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL emptyrw_count got=%0d exp=1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL emptyrw_empty got=%b exp=0", empty); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL emptyrw_udf got=%b exp=1", underflow); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL emptyrw_ovf got=%b exp=0", overflow); end
    checks++; if (r_addr !== 4'd0 || w_addr !== 4'd1) begin errors++; $display("FAIL emptyrw_ptrs got=%0d/%0d exp=1/0", w_addr, r_addr); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_w, exp_r;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      w_en = 1'b1;
      tick();
    end
    w_en = 1'b0;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL wrap_pre_count got=%0d exp=5", count); end
    for (int i = 0; i < 20; i++) begin
      exp_w = 4'((i + 5) % 13);
      exp_r = 4'(i % 13);
      w_en = 1'b1; r_en = 1'b1;
      #1;
      checks++; if (w_addr !== exp_w || r_addr !== exp_r) begin errors++; $display("FAIL wrap_ptrs[%0d] got=%0d/%0d exp=%0d/%0d", i, w_addr, r_addr, exp_w, exp_r); end
      tick();
      checks++; if (count !== 4'd5) begin errors++; $display("FAIL wrap_count[%0d] got=%0d exp=5", i, count); end
    end
    w_en = 1'b0; r_en = 1'b0;
    checks++; if (w_addr !== 4'd12 || r_addr !== 4'd7) begin errors++; $display("FAIL wrap_final got=%0d/%0d exp=12/7", w_addr, r_addr); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL wrap_err got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_clr();
    do_reset();
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      w_en = 1'b1;
      tick();
    end
    checks++; if (count !== 4'd7 || underflow !== 1'b1) begin errors++; $display("FAIL clr_pre got=%0d/%b exp=7/1", count, underflow); end
    clr = 1'b1; w_en = 1'b1;
    tick();
    clr = 1'b0; w_en = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL clr_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL clr_empty got=%b%b exp=11", empty, almost_empty); end
    checks++; if (w_addr !== 4'd0 || r_addr !== 4'd0) begin errors++; $display("FAIL clr_ptrs got=%0d/%0d exp=0/0", w_addr, r_addr); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_err got=%b%b exp=00", overflow, underflow); end
    checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL clr_full got=%b%b exp=00", full, almost_full); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
